rom_loader: RTL and testbench

Serial boot loader that fills the 256-byte pattern ROM. It receives an 8N1 UART byte stream on one pin and parses a framed image: sync byte, length, payload and checksum. Each payload byte becomes one write strobe with an incrementing address on the ROM write port. It reports completion or error on sticky status outputs.

---
 rtl/rom_loader_if.sv | 22 ++
 rtl/rom_loader.sv | 173 +++++++++++++++++
 tb/tb_rom_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// Boot-loader port bundle: UART input, ROM write port and load status.
// master = loader side, slave = ROM/host side.
interface rom_loader_if;
    logic       rx;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       load_ok;
    logic       err;

    modport master (
        input  rx,
        output wr_en, wr_addr, wr_data, busy, done, load_ok, err
    );

    modport slave (
        output rx,
        input  wr_en, wr_addr, wr_data, busy, done, load_ok, err
    );
endinterface

// File: rtl/rom_loader.sv
// Serial boot loader: 8N1 UART receiver feeding a frame parser
// (sync A5, length, payload, checksum) that writes the pattern ROM.
//
// state | meaning
// HUNT  | waiting for sync byte 0xA5, other bytes and line errors ignored
// LEN   | next byte is payload length (0 means 256)
// DATA  | each byte written to ROM and summed
// CHK   | next byte closes the checksum, frame ends
module rom_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    rom_loader_if.master bus
);

    localparam int HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BW        = $clog2(CLKS_PER_BIT);
    localparam int TW        = $clog2(TO_CYCLES);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {HUNT, LEN, DATA, CHK} state_t;

    logic          rx_meta, rx_s, rx_d;
    logic          rx_active;
    logic [BW-1:0] bit_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sample_now;
    logic          byte_valid;
    logic          frame_err;

    state_t        state;
    logic [8:0]    rem;
    logic [7:0]    addr;
    logic [7:0]    sum;
    logic [7:0]    chk_sum;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    logic          wr_en_q;
    logic [7:0]    wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          busy_q, done_q, load_ok_q, err_q;

    assign sample_now = rx_active && (bit_cnt == '0);
    assign byte_valid = sample_now && (bit_idx == 4'd9) && rx_s;
    assign frame_err  = sample_now && (bit_idx == 4'd9) && !rx_s;

    // Sync flops idle high so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
            rx_active <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            if (!rx_active) begin
                if (rx_d && !rx_s) begin
                    rx_active <= 1'b1;
                    bit_cnt   <= BW'(HALF_BIT - 1);
                    bit_idx   <= '0;
                end
            end else if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end else begin
                bit_cnt <= BW'(CLKS_PER_BIT - 1);
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd0) begin
                    if (rx_s)
                        rx_active <= 1'b0;
                end else if (bit_idx == 4'd9) begin
                    rx_active <= 1'b0;
                end else begin
                    shreg <= {rx_s, shreg[7:1]};
                end
            end
        end
    end

    // Inter-byte watchdog; only meaningful outside HUNT, where every
    // entry is preceded by a byte_valid reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (byte_valid)
            to_cnt <= TW'(TO_CYCLES - 2);
        else if (to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;
    end

    assign timeout = (to_cnt == '0);
    assign chk_sum = sum + shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            rem       <= '0;
            addr      <= '0;
            sum       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (state != HUNT && (frame_err || (timeout && !byte_valid))) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= HUNT;
            end else if (byte_valid) begin
                case (state)
                    HUNT: begin
                        if (shreg == SYNC_BYTE) begin
                            state     <= LEN;
                            load_ok_q <= 1'b0;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    LEN: begin
                        rem   <= {shreg == 8'd0, shreg};
                        addr  <= '0;
                        sum   <= '0;
                        state <= DATA;
                    end
                    DATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr;
                        wr_data_q <= shreg;
                        addr      <= addr + 8'd1;
                        sum       <= sum + shreg;
                        rem       <= rem - 9'd1;
                        if (rem == 9'd1)
                            state <= CHK;
                    end
                    CHK: begin
                        if (chk_sum == 8'd0) begin
                            done_q    <= 1'b1;
                            load_ok_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        busy_q <= 1'b0;
                        state  <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.load_ok = load_ok_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: byte-level frame model with cycle-stamped UART
// events, checked against the DUT every cycle, plus literal expectations.
module tb_rom_loader;

    localparam int CPB = 8;
    localparam int TOB = 32;
    localparam int TO  = TOB * CPB;
    localparam int BV_OFS = 2 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rom_loader_if bus();

    rom_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    typedef enum int {M_HUNT, M_LEN, M_DATA, M_CHK} mstate_t;

    ev_t        evq[$];
    int         falls[$];
    logic [7:0] wlog_a[$];
    logic [7:0] wlog_d[$];
    int         wr_cyc[$];
    int         done_cnt = 0;
    int         err_rise = -1;
    logic       prev_err = 1'b0;

    mstate_t    m_state;
    int         m_left, m_idx, m_sum, last_bv;
    logic       e_wr_en, e_busy, e_done, e_ok, e_err;
    logic [7:0] e_addr, e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_abort();
        e_err   = 1'b1;
        e_busy  = 1'b0;
        m_state = M_HUNT;
    endtask

    task automatic model_byte(input logic [7:0] d);
        case (m_state)
            M_HUNT: if (d == 8'hA5) begin
                m_state = M_LEN;
                e_ok = 1'b0; e_err = 1'b0; e_busy = 1'b1;
            end
            M_LEN: begin
                m_left  = (d == 8'd0) ? 256 : int'(d);
                m_idx   = 0;
                m_sum   = 0;
                m_state = M_DATA;
            end
            M_DATA: begin
                e_wr_en = 1'b1;
                e_addr  = 8'(m_idx);
                e_data  = d;
                m_sum   = m_sum + int'(d);
                m_idx   = m_idx + 1;
                if (m_idx == m_left) m_state = M_CHK;
            end
            default: begin
                if ((m_sum + int'(d)) % 256 == 0) begin
                    e_done = 1'b1; e_ok = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
                e_busy  = 1'b0;
                m_state = M_HUNT;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_state = M_HUNT; m_left = 0; m_idx = 0; m_sum = 0; last_bv = -1000000;
            e_wr_en = 0; e_busy = 0; e_done = 0; e_ok = 0; e_err = 0;
            e_addr = 0; e_data = 0;
            evq.delete();
            prev_err = 1'b0;
        end else begin
            chk("wr_en",   bus.wr_en,   e_wr_en);
            chk("wr_addr", bus.wr_addr, e_addr);
            chk("wr_data", bus.wr_data, e_data);
            chk("busy",    bus.busy,    e_busy);
            chk("done",    bus.done,    e_done);
            chk("load_ok", bus.load_ok, e_ok);
            chk("err",     bus.err,     e_err);
            if (bus.wr_en) begin
                wlog_a.push_back(bus.wr_addr);
                wlog_d.push_back(bus.wr_data);
                wr_cyc.push_back(cyc);
            end
            if (bus.done) done_cnt++;
            if (bus.err && !prev_err) err_rise = cyc;
            prev_err = bus.err;

            e_wr_en = 1'b0;
            e_done  = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                ev_t ev;
                ev = evq.pop_front();
                if (ev.ok) begin
                    last_bv = cyc;
                    model_byte(ev.data);
                end else if (m_state != M_HUNT) begin
                    model_abort();
                end
            end else if (m_state != M_HUNT && cyc == last_bv + TO - 1) begin
                model_abort();
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ev_t ev;
        @(posedge clk); #1;
        falls.push_back(cyc);
        ev.at = cyc + BV_OFS; ev.data = b; ev.ok = stop_ok;
        evq.push_back(ev);
        bus.rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk); #1;
            bus.rx = b[i];
        end
        repeat (CPB) @(posedge clk); #1;
        bus.rx = stop_ok;
        repeat (CPB) @(posedge clk); #1;
        bus.rx = 1'b1;
        if (!stop_ok) repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); wr_cyc.delete(); falls.delete();
        done_cnt = 0;
        err_rise = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fr[$];
        int bad;
        bus.rx = 1'b1;
        rst = 1'b1;
        idle(3);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_busy",  bus.busy,  1'b0);
        chk("rst_ok",    bus.load_ok, 1'b0);
        chk("rst_err",   bus.err,   1'b0);
        rst = 1'b0;
        idle(5);

        // good 3-byte frame
        clear_logs();
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send_frame(fr);
        idle(5);
        chk("f1_nwr", wlog_a.size(), 3);
        if (wlog_a.size() == 3) begin
            chk("f1_a0", wlog_a[0], 8'h00); chk("f1_d0", wlog_d[0], 8'h11);
            chk("f1_a1", wlog_a[1], 8'h01); chk("f1_d1", wlog_d[1], 8'h22);
            chk("f1_a2", wlog_a[2], 8'h02); chk("f1_d2", wlog_d[2], 8'h33);
            chk("f1_latency", wr_cyc[0] - falls[2], 32'd79);
        end
        chk("f1_done", done_cnt, 1);
        chk("f1_ok", bus.load_ok, 1'b1);
        chk("f1_err", bus.err, 1'b0);

        // bad checksum
        clear_logs();
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
        send_frame(fr);
        idle(5);
        chk("f2_nwr", wlog_a.size(), 3);
        chk("f2_done", done_cnt, 0);
        chk("f2_err", bus.err, 1'b1);
        chk("f2_busy", bus.busy, 1'b0);
        chk("f2_ok", bus.load_ok, 1'b0);

        // glitch and junk before sync, A5 as payload
        clear_logs();
        @(posedge clk); #1 bus.rx = 1'b0;
        @(posedge clk); #1 bus.rx = 1'b1;
        idle(3 * CPB);
        fr = '{8'h5A, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'h5A};
        send_frame(fr);
        idle(5);
        chk("f3_nwr", wlog_a.size(), 2);
        if (wlog_a.size() == 2) begin
            chk("f3_a0", wlog_a[0], 8'h00); chk("f3_d0", wlog_d[0], 8'hA5);
            chk("f3_a1", wlog_a[1], 8'h01); chk("f3_d1", wlog_d[1], 8'h01);
        end
        chk("f3_ok", bus.load_ok, 1'b1);
        chk("f3_err", bus.err, 1'b0);

        // framing error on 2nd payload byte, then recovery
        clear_logs();
        fr = '{8'hA5, 8'h04, 8'h11};
        send_frame(fr);
        send_byte(8'h22, 1'b0);
        idle(5);
        chk("f4_nwr", wlog_a.size(), 1);
        chk("f4_err", bus.err, 1'b1);
        chk("f4_busy", bus.busy, 1'b0);
        fr = '{8'hA5, 8'h01, 8'h42, 8'hBE};
        send_frame(fr);
        idle(5);
        chk("f4r_ok", bus.load_ok, 1'b1);
        chk("f4r_err", bus.err, 1'b0);

        // timeout after one payload byte
        clear_logs();
        fr = '{8'hA5, 8'h04, 8'h11};
        send_frame(fr);
        idle(TO + 20);
        chk("to_err", bus.err, 1'b1);
        chk("to_busy", bus.busy, 1'b0);
        chk("to_when", err_rise - falls[2], 32'd334);

        // 256-byte image
        clear_logs();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h80, 1'b1);
        idle(5);
        chk("big_nwr", wlog_a.size(), 256);
        bad = 0;
        foreach (wlog_a[i]) if (wlog_a[i] != 8'(i) || wlog_d[i] != 8'(i)) bad++;
        chk("big_seq", bad, 0);
        chk("big_last", bus.wr_addr, 8'hFF);
        chk("big_ok", bus.load_ok, 1'b1);
        chk("big_done", done_cnt, 1);

        // reset mid-frame
        fr = '{8'hA5, 8'h05, 8'h01};
        send_frame(fr);
        idle(2);
        chk("mid_busy", bus.busy, 1'b1);
        fork
            send_byte(8'h02, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #3 rst = 1'b1;
                #1;
                chk("rst_mid_busy", bus.busy, 1'b0);
                chk("rst_mid_wr_en", bus.wr_en, 1'b0);
                chk("rst_mid_addr", bus.wr_addr, 8'h00);
                chk("rst_mid_data", bus.wr_data, 8'h00);
                chk("rst_mid_err", bus.err, 1'b0);
                chk("rst_mid_ok", bus.load_ok, 1'b0);
            end
        join
        @(posedge clk); #1 rst = 1'b0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
